// File: rtl/spart_pkg.sv
// spart_pkg -- shared definitions for the SPART bus controller.
//   * I/O register address encodings
//   * divisor-programming FSM state type
//   * default baud divisor and the divisor clamp helper
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;  // rx read / tx write
    localparam logic [1:0] ADDR_STAT = 2'b01;  // status read / ovr clear write
    localparam logic [1:0] ADDR_DIVL = 2'b10;  // divisor low byte
    localparam logic [1:0] ADDR_DIVH = 2'b11;  // divisor high byte

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd31;
    localparam logic [15:0] DIV_MIN_DEFAULT   = 16'd1;

    typedef enum logic {
        ST_RUN     = 1'b0,  // baud generator running
        ST_LO_PEND = 1'b1   // low byte staged, waiting for the high byte
    } state_t;

    // Values below the minimum would stall or over-run the baud counter.
    function automatic logic [15:0] clamp_div(input logic [15:0] value,
                                              input logic [15:0] min_value);
        return (value < min_value) ? min_value : value;
    endfunction

endpackage

// File: rtl/spart_brg.sv
// spart_brg -- baud-rate enable generator.
// Down-counter reloaded from divisor; emits a one-cycle enable every
// divisor+1 cycles.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   divisor      reload value (must already be clamped)
//   load         reload counter from divisor now (restarts the period)
//   freeze       hold the counter and suppress the enable
//   brg_en       registered one-cycle enable pulse
module spart_brg #(
    parameter logic [15:0] DIV_RESET = 16'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        load,
    input  logic        freeze,
    output logic        brg_en
);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= DIV_RESET;
            brg_en  <= 1'b0;
        end else if (load) begin
            // load wins over freeze so a commit from the pending state restarts cleanly
            cnt_reg <= divisor;
            brg_en  <= 1'b0;
        end else if (freeze) begin
            brg_en  <= 1'b0;
        end else if (cnt_reg == 16'd0) begin
            cnt_reg <= divisor;
            brg_en  <= 1'b1;
        end else begin
            cnt_reg <= cnt_reg - 16'd1;
            brg_en  <= 1'b0;
        end
    end

endmodule

// File: rtl/spart_ctrl.sv
// spart_ctrl -- SPART bus interface and baud divisor control.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   iocs, iorw        bus select, 1 = read / 0 = write
//   ioaddr            00 data, 01 status/control, 10 div low, 11 div high
//   db_in / db_out    write data / registered read data
//   rx_buf, rda       receiver byte and data-available flag
//   rx_ack            one-cycle pulse: receiver byte consumed
//   tbr               transmitter buffer ready
//   tx_load, tx_data  one-cycle load pulse and registered transmit byte
//   brg_en            one-cycle baud enable to receiver and transmitter
module spart_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT,
    parameter logic [15:0] DIV_MIN   = DIV_MIN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    input  logic [7:0] rx_buf,
    input  logic       rda,
    input  logic       tbr,
    output logic       rx_ack,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       brg_en
);

    state_t      state_reg, state_next;
    logic [15:0] div_reg, div_next;
    logic [7:0]  lo_reg, lo_next;
    logic        ovr_reg, ovr_next;
    logic [7:0]  db_out_reg, db_out_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        rx_ack_reg, rx_ack_next;
    logic        tx_load_reg, tx_load_next;
    logic        brg_load;
    logic [15:0] commit_val;
    logic [15:0] brg_div;
    logic        lo_pend;

    assign lo_pend = (state_reg == ST_LO_PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            div_reg     <= DIV_RESET;
            lo_reg      <= 8'h00;
            ovr_reg     <= 1'b0;
            db_out_reg  <= 8'h00;
            tx_data_reg <= 8'h00;
            rx_ack_reg  <= 1'b0;
            tx_load_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            lo_reg      <= lo_next;
            ovr_reg     <= ovr_next;
            db_out_reg  <= db_out_next;
            tx_data_reg <= tx_data_next;
            rx_ack_reg  <= rx_ack_next;
            tx_load_reg <= tx_load_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        lo_next      = lo_reg;
        ovr_next     = ovr_reg;
        db_out_next  = db_out_reg;
        tx_data_next = tx_data_reg;
        rx_ack_next  = 1'b0;
        tx_load_next = 1'b0;
        brg_load     = 1'b0;
        commit_val   = div_reg;

        if (iocs) begin
            if (iorw) begin
                case (ioaddr)
                    ADDR_DATA: begin
                        db_out_next = rx_buf;
                        rx_ack_next = rda;
                    end
                    ADDR_STAT: db_out_next = {4'b0000, lo_pend, ovr_reg, tbr, rda};
                    ADDR_DIVL: db_out_next = div_reg[7:0];
                    default:   db_out_next = div_reg[15:8];
                endcase
            end else begin
                case (ioaddr)
                    ADDR_DATA: begin
                        if (tbr) begin
                            tx_data_next = db_in;
                            tx_load_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end
                    ADDR_STAT: ovr_next = 1'b0;
                    ADDR_DIVL: begin
                        lo_next    = db_in;
                        state_next = ST_LO_PEND;
                    end
                    default: begin
                        // A lone high-byte write keeps the committed low byte.
                        commit_val = clamp_div(lo_pend ? {db_in, lo_reg} : {db_in, div_reg[7:0]},
                                               DIV_MIN);
                        div_next   = commit_val;
                        brg_load   = 1'b1;
                        state_next = ST_RUN;
                    end
                endcase
            end
        end
    end

    // On a commit the counter must reload the new value, not the old register.
    assign brg_div = brg_load ? commit_val : div_reg;

    spart_brg #(
        .DIV_RESET (DIV_RESET)
    ) u_brg (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (brg_div),
        .load    (brg_load),
        .freeze  (lo_pend),
        .brg_en  (brg_en)
    );

    assign db_out  = db_out_reg;
    assign tx_data = tx_data_reg;
    assign rx_ack  = rx_ack_reg;
    assign tx_load = tx_load_reg;

endmodule
